// File: rtl/ram_dp_clr.sv
`default_nettype none
// ============================================================================
// Module  : ram_dp_clr
// Brief   : True-dual-clock-free dual-port RAM (A: R/W with byte enables,
//           B: read-only) with a DEPTH-cycle clear engine run on reset/request.
// Revision: 1.0 - initial release
// ============================================================================
module ram_dp_clr #(
    parameter int                 DATA_W   = 8,
    parameter int                 ADDR_W   = 6,
    parameter int                 RDW_MODE = 0,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_req,
    output logic                  busy,
    input  logic                  a_en,
    input  logic                  a_we,
    input  logic [DATA_W/8-1:0]   a_be,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [DATA_W-1:0]     a_din,
    output logic [DATA_W-1:0]     a_dout,
    input  logic                  b_en,
    input  logic [ADDR_W-1:0]     b_addr,
    output logic [DATA_W-1:0]     b_dout
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] a_dout_q, a_dout_d;
    logic [DATA_W-1:0] b_dout_q, b_dout_d;

    logic [DATA_W-1:0] a_old;
    logic [DATA_W-1:0] a_merged;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    assign a_old = mem_q[a_addr];

    generate
        for (genvar k = 0; k < NB; k++) begin : g_byte
            assign a_merged[8*k +: 8] = a_be[k] ? a_din[8*k +: 8] : a_old[8*k +: 8];
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (clr_req) begin
                    state_d   = S_CLEAR;
                    clr_ptr_d = '0;
                end
            end
            S_CLEAR: begin
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: the clear engine owns the single write port while active
    always_comb begin
        busy     = (state_q == S_CLEAR);
        wr_en    = 1'b0;
        wr_addr  = a_addr;
        wr_data  = a_merged;
        a_dout_d = a_dout_q;
        b_dout_d = b_dout_q;
        if (state_q == S_CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = clr_ptr_q;
            wr_data = INIT_VAL;
        end else begin
            if (a_en) begin
                if (a_we) begin
                    wr_en = 1'b1;
                    if (RDW_MODE == 0) begin
                        a_dout_d = a_old;
                    end else if (RDW_MODE == 1) begin
                        a_dout_d = a_merged;
                    end
                end else begin
                    a_dout_d = a_old;
                end
            end
            // Port B samples the array before this cycle's write lands
            if (b_en) begin
                b_dout_d = mem_q[b_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_dout_q <= '0;
            b_dout_q <= '0;
        end else begin
            a_dout_q <= a_dout_d;
            b_dout_q <= b_dout_d;
        end
    end

    assign a_dout = a_dout_q;
    assign b_dout = b_dout_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_dp_clr.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram_dp_clr
// Brief   : Scoreboard bench for ram_dp_clr; three instances, one per RDW mode.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ram_dp_clr;

    localparam int              DW    = 16;
    localparam int              AW    = 6;
    localparam int              NB    = DW / 8;
    localparam int              DEPTH = 1 << AW;
    localparam logic [DW-1:0]   INIT  = 16'h5AF0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr_req = 1'b0;
    logic          a_en = 1'b0;
    logic          a_we = 1'b0;
    logic [NB-1:0] a_be = '0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_din = '0;
    logic          b_en = 1'b0;
    logic [AW-1:0] b_addr = '0;

    logic          busy0, busy1, busy2;
    logic [DW-1:0] a_dout0, a_dout1, a_dout2;
    logic [DW-1:0] b_dout0, b_dout1, b_dout2;

    always #5 clk = ~clk;

    ram_dp_clr #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(0), .INIT_VAL(INIT)) u_m0 (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy0),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout0), .b_en(b_en), .b_addr(b_addr), .b_dout(b_dout0));
    ram_dp_clr #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(1), .INIT_VAL(INIT)) u_m1 (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy1),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout1), .b_en(b_en), .b_addr(b_addr), .b_dout(b_dout1));
    ram_dp_clr #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(2), .INIT_VAL(INIT)) u_m2 (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy2),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout2), .b_en(b_en), .b_addr(b_addr), .b_dout(b_dout2));

    typedef struct packed {
        logic          busy;
        logic [DW-1:0] a0;
        logic [DW-1:0] a1;
        logic [DW-1:0] a2;
        logic [DW-1:0] b;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: array contents plus "words left to clear"
    logic [DW-1:0] m_mem [DEPTH];
    int            m_left = 0;
    logic [DW-1:0] m_a [3];
    logic [DW-1:0] m_b = '0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d actual %h required %h", name, cyc, act, req);
        end
    endtask

    task automatic drive(input logic r, input logic c, input logic ae, input logic awe,
                         input logic [NB-1:0] be, input logic [AW-1:0] aa,
                         input logic [DW-1:0] din, input logic ben, input logic [AW-1:0] ba);
        logic [DW-1:0] old_w, bold_w, mrg;
        exp_t e;
        @(negedge clk);
        rst = r; clr_req = c; a_en = ae; a_we = awe; a_be = be;
        a_addr = aa; a_din = din; b_en = ben; b_addr = ba;
        if (r) begin
            m_left = DEPTH;
            for (int i = 0; i < 3; i++) m_a[i] = '0;
            m_b = '0;
        end else if (m_left > 0) begin
            m_mem[DEPTH - m_left] = INIT;
            m_left--;
        end else begin
            old_w  = m_mem[aa];
            bold_w = m_mem[ba];
            mrg    = old_w;
            for (int k = 0; k < NB; k++)
                if (be[k]) mrg[8*k +: 8] = din[8*k +: 8];
            if (ae) begin
                if (awe) begin
                    m_a[0] = old_w;
                    m_a[1] = mrg;
                    m_mem[aa] = mrg;
                end else begin
                    for (int i = 0; i < 3; i++) m_a[i] = old_w;
                end
            end
            if (ben) m_b = bold_w;
            if (c) m_left = DEPTH;
        end
        e.busy = (m_left > 0);
        e.a0 = m_a[0]; e.a1 = m_a[1]; e.a2 = m_a[2]; e.b = m_b;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, '0, '0, '0, 0, '0);
    endtask

    task automatic wr(input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic [NB-1:0] be);
        drive(0, 0, 1, 1, be, ad, d, 0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] ad);
        drive(0, 0, 1, 0, '0, ad, '0, 1, ad);
    endtask

    // Monitor: every clock edge presents a new output set
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cyc++;
                chk("busy_m0", {{(DW-1){1'b0}}, busy0}, {{(DW-1){1'b0}}, e.busy});
                chk("busy_m1", {{(DW-1){1'b0}}, busy1}, {{(DW-1){1'b0}}, e.busy});
                chk("busy_m2", {{(DW-1){1'b0}}, busy2}, {{(DW-1){1'b0}}, e.busy});
                chk("a_dout_m0", a_dout0, e.a0);
                chk("a_dout_m1", a_dout1, e.a1);
                chk("a_dout_m2", a_dout2, e.a2);
                chk("b_dout_m0", b_dout0, e.b);
                chk("b_dout_m1", b_dout1, e.b);
                chk("b_dout_m2", b_dout2, e.b);
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        for (int i = 0; i < 3; i++) m_a[i] = '0;

        // Reset clear then full port-B sweep
        drive(1, 0, 0, 0, '0, '0, '0, 0, '0);
        idle(DEPTH + 2);
        for (int i = 0; i < DEPTH; i++) drive(0, 0, 0, 0, '0, '0, '0, 1, AW'(i));

        // Byte-enable merge, including an all-zero mask
        wr(6'd5, 16'hAABB, 2'b11);
        wr(6'd5, 16'h1122, 2'b01);
        rd(6'd5);
        wr(6'd5, 16'hFFFF, 2'b00);
        rd(6'd5);

        // Read-during-write on port A
        wr(6'd9, 16'h003C, 2'b11);
        rd(6'd3);
        wr(6'd9, 16'h005A, 2'b01);
        rd(6'd9);

        // Address collision between port A write and port B read
        wr(6'd12, 16'h0010, 2'b11);
        drive(0, 0, 1, 1, 2'b11, 6'd12, 16'h0077, 1, 6'd12);
        drive(0, 0, 0, 0, '0, '0, '0, 1, 6'd12);

        // Runtime clear with blocked write and ignored second request
        wr(6'd0, 16'h1234, 2'b11);
        rd(6'd0);
        drive(0, 1, 0, 0, '0, '0, '0, 0, '0);
        for (int i = 1; i <= DEPTH + 2; i++) begin
            if (i == 10)      drive(0, 0, 1, 1, 2'b11, 6'd0, 16'hBEEF, 1, 6'd0);
            else if (i == 20) drive(0, 1, 1, 0, '0, 6'd1, '0, 1, 6'd1);
            else              idle(1);
        end
        rd(6'd0);
        rd(6'd12);

        // Reset during a runtime clear
        wr(6'd7, 16'hC0DE, 2'b11);
        rd(6'd7);
        drive(0, 1, 0, 0, '0, '0, '0, 0, '0);
        for (int i = 1; i < 30; i++) drive(0, 0, 1, 0, '0, 6'd7, '0, 1, 6'd7);
        drive(1, 0, 1, 1, 2'b11, 6'd7, 16'hFFFF, 1, 6'd7);
        for (int i = 0; i < DEPTH + 2; i++) drive(0, 0, 1, 0, '0, 6'd7, '0, 1, 6'd7);

        // Randomized traffic with narrow address ranges to force collisions
        for (int n = 0; n < 1500; n++) begin
            logic          r, c, ae, awe, ben;
            logic [NB-1:0] be;
            logic [AW-1:0] aa, ba;
            logic [DW-1:0] din;
            r   = ($urandom_range(0, 399) == 0);
            c   = ($urandom_range(0, 149) == 0);
            ae  = $urandom_range(0, 1) == 1;
            awe = $urandom_range(0, 1) == 1;
            be  = NB'($urandom);
            aa  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            ba  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            din = DW'($urandom);
            ben = $urandom_range(0, 1) == 1;
            drive(r, c, ae, awe, be, aa, din, ben, ba);
        end

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_dp_clr.md
RAM_DP_CLR -- requirements
Module: ram_dp_clr

Interface
- Parameters:
  - REQ-001: DATA_W, default 8, word width in bits; SHALL be a multiple of 8.
  - REQ-002: ADDR_W, default 6, address width; DEPTH SHALL equal 2**ADDR_W words.
  - REQ-003: RDW_MODE, default 0, port A read-during-write mode: 0 read-first, 1 write-first, 2 no-change.
  - REQ-004: INIT_VAL, default 0, DATA_W-bit value written to every word by the clear engine.
  - NB denotes DATA_W/8 throughout.
- Ports (name, direction, width, meaning):
  - REQ-005: clk, input, 1, clock; all state SHALL update on posedge clk only.
  - REQ-006: rst, input, 1, reset; synchronous, active-high.
  - REQ-007: clr_req, input, 1, single-cycle request to start a runtime memory clear.
  - REQ-008: busy, output, 1, high while the clear engine owns the array.
  - REQ-009: a_en, input, 1, port A access enable.
  - REQ-010: a_we, input, 1, port A write enable; qualified by a_en.
  - REQ-011: a_be, input, NB, port A byte enables; bit k covers data bits [8k+7:8k].
  - REQ-012: a_addr, input, ADDR_W, port A address.
  - REQ-013: a_din, input, DATA_W, port A write data.
  - REQ-014: a_dout, output, DATA_W, port A registered read data.
  - REQ-015: b_en, input, 1, port B read enable (port B is read-only).
  - REQ-016: b_addr, input, ADDR_W, port B address.
  - REQ-017: b_dout, output, DATA_W, port B registered read data.

Function
- REQ-018: Clear FSM SHALL have two states, IDLE and CLEAR, plus an ADDR_W-bit pointer clr_ptr.
- REQ-019: In CLEAR, each cycle SHALL write INIT_VAL to mem[clr_ptr] and increment clr_ptr.
  - When clr_ptr == DEPTH-1, the FSM SHALL go to IDLE on the next edge.
  - A full clear therefore takes exactly DEPTH cycles.
- REQ-020: busy SHALL equal (state == CLEAR).
- REQ-021: clr_req sampled high in IDLE SHALL move the FSM to CLEAR with clr_ptr = 0; busy SHALL rise the following cycle.
- REQ-022: clr_req in CLEAR SHALL be ignored; the clear is not restarted or extended.
- REQ-023: While busy = 1, port A and port B accesses SHALL be ignored: no array write, and a_dout and b_dout hold.
- REQ-024: When a_en & a_we & !busy, byte k of mem[a_addr] SHALL be updated from a_din only where a_be[k] = 1.
  - a_be = 0 SHALL leave the word unchanged but still count as a write cycle for RDW purposes.
- REQ-025: Read latency SHALL be 1 cycle on both ports.
  - a_dout updates on any enabled port A cycle, per REQ-026.
  - b_dout updates on the cycle after b_en & !busy.
- REQ-026: Port A write cycle behaviour by RDW_MODE:
  - 0: a_dout = pre-write word.
  - 1: a_dout = post-write merged word.
  - 2: a_dout holds.
  - A port A read cycle (a_we = 0) SHALL always load mem[a_addr].
- REQ-027: a_en = 0 SHALL hold a_dout; b_en = 0 SHALL hold b_dout.
- REQ-028: On an address collision (port A write and port B read to the same address in one cycle), b_dout SHALL return the pre-write word, independent of RDW_MODE.
- REQ-029: Addresses SHALL wrap naturally in ADDR_W bits; no out-of-range condition exists.

Reset
- REQ-030: rst = 1 SHALL force state = CLEAR, clr_ptr = 0, a_dout = 0 and b_dout = 0.
  - busy SHALL read 1 in the cycle after rst is sampled.
- REQ-031: Array contents SHALL NOT be cleared in a single cycle.
  - After rst deasserts, the clear SHALL take DEPTH cycles.
  - busy SHALL fall DEPTH cycles after the first cycle with rst = 0.
- REQ-032: rst asserted mid-clear SHALL restart the clear from clr_ptr = 0.
- REQ-033: rst SHALL take priority over clr_req and over all port activity.

Verification (defaults: DATA_W = 8, ADDR_W = 6, INIT_VAL = 0 unless stated)
- REQ-034: Reset clear.
  - Stimulus: pulse rst for 1 cycle, count cycles with busy = 1, then read all 64 addresses on port B.
  - Required: busy high for exactly 64 cycles; every read returns 0x00.
- REQ-035: Byte-enable write.
  - Config: DATA_W = 32.
  - Stimulus: write 0xAABBCCDD with a_be = 4'b1111 to addr 5, then 0x11223344 with a_be = 4'b0101, then read addr 5.
  - Required: read returns 0xAA22CC44.
- REQ-036: RDW modes.
  - Stimulus: mem[9] = 0x3C; port A writes 0x5A to addr 9 with a_be = 1.
  - Required a_dout next cycle: mode 0 gives 0x3C; mode 1 gives 0x5A; mode 2 gives the prior a_dout value.
- REQ-037: Collision.
  - Stimulus: in the same cycle, port A writes 0x77 to addr 12 (old value 0x10) and port B reads addr 12; then port B reads addr 12 again.
  - Required: first b_dout = 0x10; second b_dout = 0x77.
- REQ-038: Runtime clear.
  - Config: INIT_VAL = 0xFF.
  - Stimulus: memory holds data; pulse clr_req; attempt a port A write to addr 0 at busy cycle 10; pulse clr_req again at busy cycle 20.
  - Required: busy high for exactly 64 cycles; addr 0 reads 0xFF afterwards; douts held throughout.
- REQ-039: Reset mid-clear.
  - Stimulus: assert rst at busy cycle 30 of a runtime clear.
  - Required: busy stays high continuously and falls 64 cycles after rst deasserts; a_dout = b_dout = 0 immediately after the reset cycle.
